mdu_mul_pipe: RTL and testbench

// Parametrised, fully pipelined multiply / multiply-accumulate unit for the MDU.

---
 rtl/mdu_mul_pipe.sv | 140 ++++++++++++++
 tb/tb_mdu_mul_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_mul_pipe.sv
// Three-stage pipelined multiply / multiply-accumulate unit for the MDU.
// S1 forms limb partial products of the operand magnitudes, S2 sums them, S3 applies sign and HI/LO accumulate.
module mdu_mul_pipe #(
   parameter int DATA_W = 32,
   parameter int LIMB_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] opr1_i,
   input  logic [DATA_W-1:0] opr2_i,
   input  logic [DATA_W-1:0] acc_hi_i,
   input  logic [DATA_W-1:0] acc_lo_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] res_hi_o,
   output logic [DATA_W-1:0] res_lo_o,
   output logic              busy_o
);

   localparam int NL = DATA_W / LIMB_W;
   localparam int PW = 2 * LIMB_W;
   localparam int RW = 2 * DATA_W;

   // Magnitude of a possibly signed operand; the most negative value maps to 2^(DATA_W-1).
   function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] x, input logic sgn);
      return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

   // Modes 00 and the reserved 11 both behave as a plain multiply; wraps modulo 2^RW.
   function automatic logic [RW-1:0] f_acc(input logic [1:0] mode, input logic [RW-1:0] acc,
                                           input logic [RW-1:0] prod);
      case (mode)
         2'b01:   return acc + prod;
         2'b10:   return acc - prod;
         default: return prod;
      endcase
   endfunction

   logic                   r_vld_p1, r_vld_p2, r_vld_p3;
   logic [NL*NL-1:0][PW-1:0] r_pp_p1;
   logic                   r_neg_p1, r_neg_p2;
   logic [1:0]             r_mode_p1, r_mode_p2;
   logic [RW-1:0]          r_acc_p1, r_acc_p2;
   logic [RW-1:0]          r_p_p2;
   logic [RW-1:0]          r_res_p3;

   logic                   w_adv3, w_ld3, w_ld2, w_accept;
   logic [DATA_W-1:0]      w_mag1, w_mag2;
   logic [NL*NL-1:0][PW-1:0] w_pp;
   logic [RW-1:0]          w_sum, w_prod;
   logic                   w_neg;

   // A stage advances exactly when the stage below loads from it, so bubbles collapse under a stall.
   assign w_adv3     = r_vld_p3 & out_ready_i;
   assign w_ld3      = r_vld_p2 & (~r_vld_p3 | w_adv3);
   assign w_ld2      = r_vld_p1 & (~r_vld_p2 | w_ld3);
   assign in_ready_o = ~flush_i & (~r_vld_p1 | w_ld2);
   assign w_accept   = in_valid_i & in_ready_o;

   assign w_mag1 = f_mag(opr1_i, op_i[0]);
   assign w_mag2 = f_mag(opr2_i, op_i[0]);
   assign w_neg  = op_i[0] & (opr1_i[DATA_W-1] ^ opr2_i[DATA_W-1]);

   always_comb begin
      w_pp = '0;
      for (int i = 0; i < NL; i++) begin
         for (int j = 0; j < NL; j++) begin
            w_pp[i*NL+j] = {{LIMB_W{1'b0}}, w_mag1[i*LIMB_W +: LIMB_W]} *
                           {{LIMB_W{1'b0}}, w_mag2[j*LIMB_W +: LIMB_W]};
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NL; i++) begin
         for (int j = 0; j < NL; j++) begin
            w_sum = w_sum + (RW'(r_pp_p1[i*NL+j]) << ((i + j) * LIMB_W));
         end
      end
   end

   assign w_prod = r_neg_p2 ? (~r_p_p2 + 1'b1) : r_p_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_vld_p3  <= 1'b0;
         r_pp_p1   <= '0;
         r_neg_p1  <= 1'b0;
         r_neg_p2  <= 1'b0;
         r_mode_p1 <= '0;
         r_mode_p2 <= '0;
         r_acc_p1  <= '0;
         r_acc_p2  <= '0;
         r_p_p2    <= '0;
         r_res_p3  <= '0;
      end else begin
         // Stage 1: partial products, sign and accumulate operand
         if (w_accept) begin
            r_pp_p1   <= w_pp;
            r_neg_p1  <= w_neg;
            r_mode_p1 <= op_i[2:1];
            r_acc_p1  <= {acc_hi_i, acc_lo_i};
         end
         // Stage 2: unsigned product magnitude
         if (w_ld2) begin
            r_p_p2    <= w_sum;
            r_neg_p2  <= r_neg_p1;
            r_mode_p2 <= r_mode_p1;
            r_acc_p2  <= r_acc_p1;
         end
         // Stage 3: signed product and accumulate, drives outputs
         if (w_ld3) begin
            r_res_p3 <= f_acc(r_mode_p2, r_acc_p2, w_prod);
         end

         if (flush_i) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
         end else begin
            r_vld_p1 <= w_accept | (r_vld_p1 & ~w_ld2);
            r_vld_p2 <= w_ld2    | (r_vld_p2 & ~w_ld3);
            r_vld_p3 <= w_ld3    | (r_vld_p3 & ~w_adv3);
         end
      end
   end

   assign out_valid_o = r_vld_p3;
   assign res_hi_o    = r_res_p3[RW-1:DATA_W];
   assign res_lo_o    = r_res_p3[DATA_W-1:0];
   assign busy_o      = r_vld_p1 | r_vld_p2 | r_vld_p3;

endmodule

// File: tb/tb_mdu_mul_pipe.sv
// Directed and scoreboard-checked bench for mdu_mul_pipe at DATA_W=32, LIMB_W=16.
module tb_mdu_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [2:0]  op_i = '0;
   logic [31:0] opr1_i = '0, opr2_i = '0, acc_hi_i = '0, acc_lo_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] res_hi_o, res_lo_o;
   logic        busy_o;

   int n_chk = 0;
   int n_fail = 0;

   mdu_mul_pipe #(.DATA_W(32), .LIMB_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
      .opr1_i(opr1_i), .opr2_i(opr2_i), .acc_hi_i(acc_hi_i), .acc_lo_i(acc_lo_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .res_hi_o(res_hi_o), .res_lo_o(res_lo_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
      op_i = op; opr1_i = a; opr2_i = b; acc_hi_i = hi; acc_lo_i = lo;
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      logic [63:0] p;
      logic [63:0] acc;
      acc = {hi, lo};
      if (op[0]) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      else       p = {32'b0, a} * {32'b0, b};
      case (op[2:1])
         2'b01:   return acc + p;
         2'b10:   return acc - p;
         default: return p;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [63:0] exp);
      @(negedge clk);
      drive(op, a, b, hi, lo);
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      in_valid_i = 1'b0;
      chk({tag, "_lat1"}, 64'(out_valid_o), 64'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, 64'(out_valid_o), 64'd0);
      @(negedge clk);
      chk({tag, "_lat3"}, 64'(out_valid_o), 64'd1);
      chk({tag, "_res"}, {res_hi_o, res_lo_o}, exp);
   endtask

   logic [63:0] exp4 [5];
   logic [63:0] q [$];

   initial begin
      int n_in, n_out, cyc, n_rnd;
      logic taken;
      logic [2:0]  r_op;
      logic [31:0] ra, rb, rh, rl;

      repeat (2) @(negedge clk);
      chk("rst_inrdy", 64'(in_ready_o), 64'd1);
      chk("rst_ovld", 64'(out_valid_o), 64'd0);
      chk("rst_res", {res_hi_o, res_lo_o}, 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      rst_n = 1'b1;

      run_op("mult_s",   3'b001, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFFE);
      run_op("multu",    3'b000, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 64'h00000001_FFFFFFFE);
      run_op("mult_min", 3'b001, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 64'h40000000_00000000);
      run_op("maddu",    3'b010, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0);
      run_op("msub",     3'b101, 32'h3, 32'h2, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFFA);
      run_op("mult_neg", 3'b001, 32'hFFFFFFFD, 32'h5, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFF1);
      run_op("madd_s",   3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hA, 64'h9);
      run_op("resv",     3'b111, 32'h2, 32'h3, 32'h5, 32'h5, 64'h6);
      run_op("multu_ff", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 64'hFFFFFFFE_00000001);
      run_op("mult_ff",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 64'h1);

      // Back-to-back with a four-cycle output stall
      for (int k = 0; k < 5; k++) exp4[k] = 64'((k + 1) * (k + 10));
      n_in = 0; n_out = 0;
      @(negedge clk);
      for (int c = 0; c < 40 && n_out < 5; c++) begin
         if (c > 0) @(negedge clk);
         out_ready_i = (c >= 7);
         if (n_in < 5) begin
            drive(3'b000, 32'(n_in + 1), 32'(n_in + 10), 32'h0, 32'h0);
            in_valid_i = 1'b1;
         end else begin
            in_valid_i = 1'b0;
         end
         #1;
         if (c >= 3 && c <= 6) chk("bp_inrdy_stall", 64'(in_ready_o), 64'd0);
         if (out_valid_o && !out_ready_i) chk("bp_hold", {res_hi_o, res_lo_o}, exp4[n_out]);
         if (out_valid_o && out_ready_i) begin
            chk("bp_order", {res_hi_o, res_lo_o}, exp4[n_out]);
            n_out++;
         end
         if (in_valid_i && in_ready_o) n_in++;
      end
      in_valid_i = 1'b0;
      chk("bp_count", 64'(n_out), 64'd5);
      repeat (3) @(negedge clk);
      chk("bp_nodup", 64'(out_valid_o), 64'd0);
      chk("bp_idle", 64'(busy_o), 64'd0);

      // Flush with three in flight and an op on offer
      out_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(3'b000, 32'(k + 2), 32'h3, 32'h0, 32'h0);
         in_valid_i = 1'b1;
         @(negedge clk);
      end
      chk("fl_full_busy", 64'(busy_o), 64'd1);
      chk("fl_full_ovld", 64'(out_valid_o), 64'd1);
      drive(3'b000, 32'h7, 32'h7, 32'h0, 32'h0);
      flush_i = 1'b1;
      #1;
      chk("fl_inrdy", 64'(in_ready_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk("fl_ovld", 64'(out_valid_o), 64'd0);
      chk("fl_busy", 64'(busy_o), 64'd0);
      out_ready_i = 1'b1;
      repeat (4) @(negedge clk);
      chk("fl_noaccept", 64'(out_valid_o | busy_o), 64'd0);
      run_op("fl_recover", 3'b000, 32'h4, 32'h4, 32'h0, 32'h0, 64'h10);

      // Asynchronous reset with a held result on the outputs
      @(negedge clk);
      drive(3'b000, 32'h5, 32'h7, 32'h0, 32'h0);
      in_valid_i = 1'b1;
      out_ready_i = 1'b0;
      @(negedge clk);
      in_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("ar_pre_res", {res_hi_o, res_lo_o}, 64'd35);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ovld", 64'(out_valid_o), 64'd0);
      chk("ar_res", {res_hi_o, res_lo_o}, 64'd0);
      chk("ar_busy", 64'(busy_o), 64'd0);
      chk("ar_inrdy", 64'(in_ready_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Random ops against the reference model with random backpressure
      n_rnd = 0; cyc = 0; taken = 1'b0;
      while ((n_rnd < 300 || q.size() > 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (taken) in_valid_i = 1'b0;
         taken = 1'b0;
         out_ready_i = ($urandom_range(0, 3) != 0);
         if (!in_valid_i && n_rnd < 300 && $urandom_range(0, 3) != 0) begin
            r_op = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            drive(r_op, ra, rb, rh, rl);
            in_valid_i = 1'b1;
         end
         #1;
         if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) chk("rnd_spurious", 64'd1, 64'd0);
            else chk("rnd_res", {res_hi_o, res_lo_o}, q.pop_front());
         end
         if (in_valid_i && in_ready_o) begin
            q.push_back(model(op_i, opr1_i, opr2_i, acc_hi_i, acc_lo_i));
            n_rnd++;
            taken = 1'b1;
         end
      end
      in_valid_i = 1'b0;
      chk("rnd_issued", 64'(n_rnd), 64'd300);
      chk("rnd_drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
